// File: rtl/delay_interval_meter.sv
// ============================================================================
// Module   : delay_interval_meter
// Purpose  : Measures start-to-stop delay in prescaled ticks, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_interval_meter #(
  parameter int TICK_CYCLES   = 2500000,
  parameter int PRE_W         = 22,
  parameter int COUNT_W       = 8,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic               iCLOCK50,
  input  logic               iRST_N,
  input  logic               iSTART,
  input  logic               iSTOP,
  input  logic               iCLEAR,
  output logic               oBUSY,
  output logic               oDONE,
  output logic               oVALID,
  output logic               oTIMEOUT,
  output logic [COUNT_W-1:0] oTICKS
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PRE_W-1:0]   C_PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam logic [COUNT_W-1:0] C_TIMEOUT  = COUNT_W'(TIMEOUT_TICKS);

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               start_prev_q, start_prev_d;
  logic               stop_prev_q, stop_prev_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic [COUNT_W-1:0] ticks_q, ticks_d;

  logic               start_edge;
  logic               stop_edge;
  logic               tick;
  logic [COUNT_W-1:0] count_inc;

  assign start_edge = iSTART & ~start_prev_q;
  assign stop_edge  = iSTOP & ~stop_prev_q;
  assign tick       = (state_q == RUN) && (pre_q == C_PRE_LAST);
  assign count_inc  = count_q + 1'b1;

  // Priority: clear, then start (arm/re-arm), then stop, then tick/timeout.
  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    count_d      = count_q;
    start_prev_d = iSTART;
    stop_prev_d  = iSTOP;
    busy_d       = busy_q;
    done_d       = 1'b0;
    valid_d      = valid_q;
    timeout_d    = timeout_q;
    ticks_d      = ticks_q;

    if (iCLEAR) begin
      state_d   = IDLE;
      pre_d     = '0;
      count_d   = '0;
      busy_d    = 1'b0;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      ticks_d   = '0;
    end else if (start_edge) begin
      state_d   = RUN;
      pre_d     = '0;
      count_d   = '0;
      busy_d    = 1'b1;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      ticks_d   = '0;
    end else if (state_q == RUN) begin
      if (stop_edge) begin
        // Stop beats a coincident tick, so the pre-increment count is reported.
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        valid_d = 1'b1;
        ticks_d = count_q;
      end else if (tick) begin
        pre_d   = '0;
        count_d = count_inc;
        if (count_inc == C_TIMEOUT) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          ticks_d   = C_TIMEOUT;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLOCK50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      count_q      <= '0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      ticks_q      <= '0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      count_q      <= count_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      ticks_q      <= ticks_d;
    end
  end

  assign oBUSY    = busy_q;
  assign oDONE    = done_q;
  assign oVALID   = valid_q;
  assign oTIMEOUT = timeout_q;
  assign oTICKS   = ticks_q;

endmodule

`default_nettype wire

// File: tb/tb_delay_interval_meter.sv
// ============================================================================
// Module   : tb_delay_interval_meter
// Purpose  : Scoreboard bench for delay_interval_meter (TICK=10, TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_interval_meter;

  typedef struct packed {
    logic [7:0] ticks;
    logic       valid;
    logic       tmo;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       clear;
  logic       busy;
  logic       done;
  logic       valid;
  logic       tmo;
  logic [7:0] ticks;

  int   tests;
  int   fails;
  exp_t sb_q[$];
  logic done_prev;

  delay_interval_meter #(
    .TICK_CYCLES  (10),
    .PRE_W        (4),
    .COUNT_W      (8),
    .TIMEOUT_TICKS(4)
  ) dut (
    .iCLOCK50(clk),
    .iRST_N  (rst_n),
    .iSTART  (start),
    .iSTOP   (stop),
    .iCLEAR  (clear),
    .oBUSY   (busy),
    .oDONE   (done),
    .oVALID  (valid),
    .oTIMEOUT(tmo),
    .oTICKS  (ticks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
    check({tag, " valid"}, int'(valid), 0);
    check({tag, " timeout"}, int'(tmo), 0);
    check({tag, " ticks"}, int'(ticks), 0);
  endtask

  // Monitor: every oDONE pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev <= 1'b0;
    end else begin
      if (done_prev) check("done one-cycle", int'(done), 0);
      if (done) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected done: ticks=%0d valid=%0d timeout=%0d",
                   ticks, valid, tmo);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb ticks", int'(ticks), int'(e.ticks));
          check("sb valid", int'(valid), int'(e.valid));
          check("sb timeout", int'(tmo), int'(e.tmo));
          check("sb busy", int'(busy), 0);
        end
      end
      done_prev <= done;
    end
  end

  initial begin
    tests     = 0;
    fails     = 0;
    done_prev = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    clear     = 1'b0;
    wait_neg(2);
    check_idle_zero("reset");
    rst_n = 1'b1;
    wait_neg(3);

    // 1: start at edge 0, stop at edge 25 -> ticks 2, valid
    start = 1'b1;
    wait_neg(1);
    check("t1 busy after start", int'(busy), 1);
    start = 1'b0;
    wait_neg(24);
    stop = 1'b1;
    sb_q.push_back('{ticks: 8'd2, valid: 1'b1, tmo: 1'b0});
    wait_neg(1);
    stop = 1'b0;
    wait_neg(3);
    check("t1 busy low", int'(busy), 0);
    check("t1 ticks held", int'(ticks), 2);
    check("t1 valid held", int'(valid), 1);

    // 2: stop coincides with timeout tick at edge 40 -> ticks 3, valid
    start = 1'b1;
    wait_neg(1);
    check("t2 valid cleared", int'(valid), 0);
    check("t2 ticks cleared", int'(ticks), 0);
    start = 1'b0;
    wait_neg(39);
    stop = 1'b1;
    sb_q.push_back('{ticks: 8'd3, valid: 1'b1, tmo: 1'b0});
    wait_neg(1);
    stop = 1'b0;
    wait_neg(3);
    check("t2 timeout", int'(tmo), 0);
    check("t2 valid", int'(valid), 1);

    // 3: no stop -> timeout at edge 40, later stops ignored
    start = 1'b1;
    sb_q.push_back('{ticks: 8'd4, valid: 1'b0, tmo: 1'b1});
    wait_neg(1);
    start = 1'b0;
    wait_neg(38);
    check("t3 busy before timeout", int'(busy), 1);
    wait_neg(6);
    check("t3 timeout", int'(tmo), 1);
    check("t3 valid", int'(valid), 0);
    check("t3 ticks", int'(ticks), 4);
    check("t3 busy", int'(busy), 0);
    stop = 1'b1;
    wait_neg(2);
    stop = 1'b0;
    wait_neg(2);
    check("t3 ticks held", int'(ticks), 4);
    check("t3 timeout held", int'(tmo), 1);

    // 4: re-arm at edge 15, stop at edge 38 -> ticks 2
    start = 1'b1;
    wait_neg(1);
    start = 1'b0;
    wait_neg(14);
    start = 1'b1;
    wait_neg(1);
    start = 1'b0;
    check("t4 busy after rearm", int'(busy), 1);
    wait_neg(22);
    stop = 1'b1;
    sb_q.push_back('{ticks: 8'd2, valid: 1'b1, tmo: 1'b0});
    wait_neg(1);
    stop = 1'b0;
    wait_neg(3);

    // 5: clear at edge 12 aborts; stop at edge 20 ignored
    start = 1'b1;
    wait_neg(1);
    start = 1'b0;
    wait_neg(11);
    clear = 1'b1;
    wait_neg(1);
    clear = 1'b0;
    check_idle_zero("t5 clear");
    wait_neg(7);
    stop = 1'b1;
    wait_neg(1);
    stop = 1'b0;
    wait_neg(3);
    check("t5 busy after stop", int'(busy), 0);
    check("t5 valid after stop", int'(valid), 0);

    // 6: start held through reset release, then async reset mid-run
    rst_n = 1'b0;
    start = 1'b1;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(1);
    check("t6 busy after release", int'(busy), 1);
    start = 1'b0;
    wait_neg(15);
    check("t6 ticks pre-reset", int'(ticks), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("t6 async reset");
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(3);
    check("t6 busy after reset", int'(busy), 0);

    check("scoreboard drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/delay_interval_meter.md
Name: delay_interval_meter

Overview:
- Measures the delay between a trigger and its response, in units of a ~50 ms prescaled tick. It is the receive/measurement counterpart of the staged delayed-pulse generator.
- On an iSTART rising edge it arms and counts whole ticks. On an iSTOP rising edge it reports the elapsed tick count.
- If no stop edge arrives within a bounded window, it reports a timeout instead.
- Typical use: confirming that a downstream SLM/timer stage responded within its expected 100/200/300/400 ms slot.

Parameters:
- TICK_CYCLES, 2500000, iCLOCK50 cycles per tick (~50 ms at 50 MHz); must be >= 2.
- PRE_W, 22, prescaler width; 2^PRE_W must be > TICK_CYCLES-1.
- COUNT_W, 8, width of the tick counter and result.
- TIMEOUT_TICKS, 16, tick count at which the measurement aborts; range 1..2^COUNT_W-1.

Ports:
- iCLOCK50  in  1  system clock, 50 MHz; all logic on its rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- iSTART  in  1  level input, synchronous to iCLOCK50; a rising edge arms or re-arms the measurement.
- iSTOP  in  1  level input, synchronous to iCLOCK50; a rising edge ends the measurement.
- iCLEAR  in  1  synchronous clear of results; aborts a running measurement.
- oBUSY  out  1  high while in RUN.
- oDONE  out  1  one-cycle pulse when a measurement completes, by stop or by timeout.
- oVALID  out  1  held high after a stop-terminated measurement.
- oTIMEOUT  out  1  held high after a timeout-terminated measurement.
- oTICKS  out  COUNT_W  captured tick count; held until the next start edge or clear.

Behaviour:
- Reset (iRST_N low, asynchronous):
  - state=IDLE, prescaler=0, count=0.
  - start_prev=0, stop_prev=0.
  - All outputs 0.
- Edge detection:
  - start_edge = iSTART & ~start_prev; stop_edge = iSTOP & ~stop_prev.
  - The prev registers update every cycle.
  - A level already high when reset releases produces an edge on the first clock.
- Priority, evaluated per clock: iCLEAR > start_edge > stop_edge > tick/timeout.
- IDLE:
  - start_edge: go to RUN; prescaler=0, count=0, oVALID=0, oTIMEOUT=0, oTICKS=0; oBUSY=1 from the next cycle.
  - stop_edge alone: ignored.
  - A start and a stop edge in the same cycle: the start is taken and the stop is ignored.
- RUN, prescaler handling:
  - If prescaler == TICK_CYCLES-1, then prescaler=0 and a tick fires; otherwise prescaler increments.
  - A tick sets count = count+1.
  - With the start edge at clock edge 0, ticks fire at edges TICK_CYCLES, 2*TICK_CYCLES, ...
- RUN, stop_edge at clock edge k:
  - Go to IDLE; oTICKS = count as held before this edge, i.e. floor((k-1)/TICK_CYCLES).
  - oVALID=1, oDONE=1 for one cycle, oBUSY=0.
- RUN, stop_edge in the same cycle as a tick:
  - Stop wins; the pre-increment count is captured.
  - This also applies when that tick would cause a timeout: the result is a valid result, not a timeout.
- RUN, timeout:
  - Occurs when a tick would make count == TIMEOUT_TICKS, i.e. at edge TIMEOUT_TICKS*TICK_CYCLES.
  - Go to IDLE; oTICKS=TIMEOUT_TICKS, oTIMEOUT=1, oVALID=0, oDONE=1 for one cycle.
- RUN, start_edge: re-arm. The state stays RUN, prescaler=0, count=0, no oDONE. This also applies when a stop edge arrives in the same cycle.
- iCLEAR, in any state:
  - Go to IDLE; prescaler=0, count=0.
  - oTICKS=0, oVALID=0, oTIMEOUT=0, oDONE=0, oBUSY=0.
  - A start edge coincident with iCLEAR is discarded; start_prev still updates.
- Invariants:
  - count never exceeds TIMEOUT_TICKS, so no wrap occurs.
  - oVALID and oTIMEOUT are never high together.
  - oDONE is only high in the cycle after the RUN->IDLE transition edge, i.e. it is registered.
- Reset mid-RUN: immediate return to IDLE and reset values; no oDONE.

Test Plan:
- Common bench parameters: TICK_CYCLES=10, TIMEOUT_TICKS=4.
1. Start edge at edge 0, stop edge at edge 25 -> one oDONE pulse, oTICKS=2, oVALID=1, oTIMEOUT=0, oBUSY low after edge 25.
2. Start at edge 0, stop at edge 40 (stop coincides with the timeout tick) -> oTICKS=3, oVALID=1, oTIMEOUT=0.
3. Start at edge 0, no stop -> at edge 40, oTIMEOUT=1, oTICKS=4, oVALID=0, one oDONE pulse; later stop edges are ignored and outputs are held.
4. Start at edge 0, second start edge at edge 15, stop at edge 38 -> no oDONE at edge 15; final oTICKS=2, measured from edge 15.
5. Start at edge 0, iCLEAR at edge 12 -> IDLE, all outputs 0, no oDONE. A stop at edge 20 is ignored.
6. iSTART held high through reset release -> edge on the first clock and RUN entered. Asserting iRST_N low mid-RUN -> outputs 0 asynchronously.
